// File: rtl/display_fb_if.sv
// Frame-buffer access bundle between the game/scan requesters and the frame-buffer responder.
// master = requester side (scanner + game logic), slave = responder.
interface display_fb_if #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 2
);
    logic              rd_req;
    logic              rd_grant;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;
    logic              wr_req;
    logic              wr_grant;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              clr_start;
    logic              clr_busy;
    logic              clr_done;

    modport master (
        output rd_req, rd_addr, wr_req, wr_en, wr_addr, wr_data, clr_start,
        input  rd_grant, rd_valid, rd_data, wr_grant, clr_busy, clr_done
    );

    modport slave (
        input  rd_req, rd_addr, wr_req, wr_en, wr_addr, wr_data, clr_start,
        output rd_grant, rd_valid, rd_data, wr_grant, clr_busy, clr_done
    );
endinterface

// File: rtl/display_fb_responder.sv
// Owns the 8x8 two-colour frame buffer and arbitrates the scanner reader, the
// game-logic writer and the internal clear sweep.
module display_fb_responder #(
    parameter int ADDR_W       = 6,
    parameter int DATA_W       = 2,
    parameter int STARVE_LIMIT = 12
) (
    input  logic         scan_clk,
    input  logic         rst_n_,
    display_fb_if.slave  bus
);
    localparam int DEPTH  = 2 ** ADDR_W;
    localparam int WAIT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX   = WAIT_W'(STARVE_LIMIT);
    localparam logic [WAIT_W-1:0] WAIT_ONE   = {{(WAIT_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] SWEEP_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] SWEEP_LAST = {ADDR_W{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RD_OWN = 2'd1,
        ST_WR_OWN = 2'd2,
        ST_CLEAR  = 2'd3
    } state_t;

    state_t            state_r;
    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [ADDR_W-1:0] sweep_cnt_r;
    logic [WAIT_W-1:0] wr_wait_cnt_r;
    logic              clr_pending_r;
    logic              rd_grant_r;
    logic              wr_grant_r;
    logic              rd_valid_r;
    logic [DATA_W-1:0] rd_data_r;
    logic              clr_busy_r;
    logic              clr_done_r;
    logic              starved_s;

    assign starved_s = (wr_wait_cnt_r == WAIT_MAX);

    assign bus.rd_grant = rd_grant_r;
    assign bus.wr_grant = wr_grant_r;
    assign bus.rd_valid = rd_valid_r;
    assign bus.rd_data  = rd_data_r;
    assign bus.clr_busy = clr_busy_r;
    assign bus.clr_done = clr_done_r;

    // Writer starvation counter: counts ungranted request cycles, saturating.
    always_ff @(posedge scan_clk or negedge rst_n_) begin
        if (!rst_n_) begin
            wr_wait_cnt_r <= '0;
        end else if (wr_grant_r) begin
            wr_wait_cnt_r <= '0;
        end else if (bus.wr_req && !starved_s) begin
            wr_wait_cnt_r <= wr_wait_cnt_r + WAIT_ONE;
        end else begin
            wr_wait_cnt_r <= wr_wait_cnt_r;
        end
    end

    // Clear request latch; a pulse arriving during a sweep re-arms it for another sweep.
    always_ff @(posedge scan_clk or negedge rst_n_) begin
        if (!rst_n_) begin
            clr_pending_r <= 1'b0;
        end else if (bus.clr_start) begin
            clr_pending_r <= 1'b1;
        end else if (state_r == ST_IDLE && clr_pending_r) begin
            clr_pending_r <= 1'b0;
        end else begin
            clr_pending_r <= clr_pending_r;
        end
    end

    // Frame buffer storage: cleared by the sweep or written by the granted writer.
    always_ff @(posedge scan_clk or negedge rst_n_) begin
        if (!rst_n_) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else if (state_r == ST_CLEAR) begin
            mem_r[sweep_cnt_r] <= '0;
        end else if (state_r == ST_WR_OWN && bus.wr_en) begin
            mem_r[bus.wr_addr] <= bus.wr_data;
        end
    end

    // Ownership FSM with grants, read data and sweep status registered alongside the state.
    always_ff @(posedge scan_clk or negedge rst_n_) begin
        if (!rst_n_) begin
            state_r     <= ST_IDLE;
            rd_grant_r  <= 1'b0;
            wr_grant_r  <= 1'b0;
            rd_valid_r  <= 1'b0;
            rd_data_r   <= '0;
            clr_busy_r  <= 1'b0;
            clr_done_r  <= 1'b0;
            sweep_cnt_r <= '0;
        end else begin
            rd_valid_r <= 1'b0;
            clr_done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (clr_pending_r) begin
                        state_r     <= ST_CLEAR;
                        clr_busy_r  <= 1'b1;
                        sweep_cnt_r <= '0;
                    end else if (bus.wr_req && starved_s) begin
                        state_r    <= ST_WR_OWN;
                        wr_grant_r <= 1'b1;
                    end else if (bus.rd_req) begin
                        state_r    <= ST_RD_OWN;
                        rd_grant_r <= 1'b1;
                    end else if (bus.wr_req) begin
                        state_r    <= ST_WR_OWN;
                        wr_grant_r <= 1'b1;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_RD_OWN: begin
                    // No read on the leaving edge, so rd_valid never outlives rd_grant.
                    if (!bus.rd_req || starved_s || clr_pending_r) begin
                        state_r    <= ST_IDLE;
                        rd_grant_r <= 1'b0;
                    end else begin
                        rd_valid_r <= 1'b1;
                        rd_data_r  <= mem_r[bus.rd_addr];
                    end
                end
                ST_WR_OWN: begin
                    if (!bus.wr_req || clr_pending_r) begin
                        state_r    <= ST_IDLE;
                        wr_grant_r <= 1'b0;
                    end else begin
                        state_r <= ST_WR_OWN;
                    end
                end
                ST_CLEAR: begin
                    if (sweep_cnt_r == SWEEP_LAST) begin
                        state_r    <= ST_IDLE;
                        clr_busy_r <= 1'b0;
                        clr_done_r <= 1'b1;
                    end else begin
                        sweep_cnt_r <= sweep_cnt_r + SWEEP_ONE;
                    end
                end
                default: begin
                    state_r    <= ST_IDLE;
                    rd_grant_r <= 1'b0;
                    wr_grant_r <= 1'b0;
                    clr_busy_r <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_display_fb_responder.sv
// Self-checking bench for display_fb_responder: transaction-level memory model,
// expected read data queued at issue time and popped by an independent monitor.
module tb_display_fb_responder;
    localparam int ADDR_W = 6;
    localparam int DATA_W = 2;
    localparam int STARVE = 12;
    localparam int DEPTH  = 64;

    logic scan_clk = 1'b0;
    logic rst_n_;

    display_fb_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus_if ();

    display_fb_responder #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_LIMIT(STARVE)) dut (
        .scan_clk (scan_clk),
        .rst_n_   (rst_n_),
        .bus      (bus_if)
    );

    always #5 scan_clk = ~scan_clk;

    int n_cmp  = 0;
    int n_fail = 0;
    logic [DATA_W-1:0] model_mem [DEPTH];
    logic [DATA_W-1:0] exp_q [$];

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every rd_valid must match the oldest outstanding read.
    always @(negedge scan_clk) begin
        if (rst_n_ === 1'b1 && bus_if.rd_valid === 1'b1) begin
            check("rd_valid_under_grant", int'(bus_if.rd_grant), 1);
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL rd_valid_unexpected: got rd_valid=1 data=%0d, expected no read outstanding", bus_if.rd_data);
            end else begin
                check("rd_data", int'(bus_if.rd_data), int'(exp_q.pop_front()));
            end
        end
    end

    task automatic tick();
        @(posedge scan_clk);
        #1;
    endtask

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
    endtask

    task automatic rd_one(input logic [ADDR_W-1:0] a);
        bus_if.rd_addr = a;
        exp_q.push_back(model_mem[a]);
        tick();
        check("rd_valid_latency", int'(bus_if.rd_valid), 1);
    endtask

    task automatic wr_one(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        bus_if.wr_en   = 1'b1;
        bus_if.wr_addr = a;
        bus_if.wr_data = d;
        model_mem[a]   = d;
        tick();
        bus_if.wr_en = 1'b0;
    endtask

    task automatic acquire_rd();
        bus_if.rd_req = 1'b1;
        tick();
        check("rd_grant_latency", int'(bus_if.rd_grant), 1);
    endtask

    task automatic release_rd();
        bus_if.rd_req = 1'b0;
        tick();
        check("rd_grant_release", int'(bus_if.rd_grant), 0);
    endtask

    task automatic acquire_wr();
        bus_if.wr_req = 1'b1;
        tick();
        check("wr_grant_latency", int'(bus_if.wr_grant), 1);
    endtask

    task automatic release_wr();
        bus_if.wr_req = 1'b0;
        bus_if.wr_en  = 1'b0;
        tick();
        check("wr_grant_release", int'(bus_if.wr_grant), 0);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_rd_grant"}, int'(bus_if.rd_grant), 0);
        check({tag, "_wr_grant"}, int'(bus_if.wr_grant), 0);
        check({tag, "_rd_valid"}, int'(bus_if.rd_valid), 0);
        check({tag, "_rd_data"},  int'(bus_if.rd_data),  0);
        check({tag, "_clr_busy"}, int'(bus_if.clr_busy), 0);
        check({tag, "_clr_done"}, int'(bus_if.clr_done), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [ADDR_W-1:0] base;
        int wait_m;
        int busy_cycles;
        int n;

        rst_n_           = 1'b0;
        bus_if.rd_req    = 1'b0;
        bus_if.rd_addr   = '0;
        bus_if.wr_req    = 1'b0;
        bus_if.wr_en     = 1'b0;
        bus_if.wr_addr   = '0;
        bus_if.wr_data   = '0;
        bus_if.clr_start = 1'b0;
        model_clear();
        repeat (3) tick();
        check_idle_outputs("reset");
        rst_n_ = 1'b1;
        tick();
        check_idle_outputs("post_reset");

        // Directed write then read-back of two cells.
        acquire_wr();
        wr_one(6'd9, 2'b10);
        wr_one(6'd63, 2'b01);
        release_wr();
        acquire_rd();
        rd_one(6'd9);
        rd_one(6'd63);
        release_rd();

        // Simultaneous requests: reader first, writer right after the reader lets go.
        bus_if.rd_req = 1'b1;
        bus_if.wr_req = 1'b1;
        tick();
        check("tie_rd_grant", int'(bus_if.rd_grant), 1);
        check("tie_wr_grant", int'(bus_if.wr_grant), 0);
        for (int i = 0; i < 8; i++) rd_one(ADDR_W'($urandom_range(0, DEPTH - 1)));
        bus_if.rd_req = 1'b0;
        tick();
        check("tie_rd_release", int'(bus_if.rd_grant), 0);
        check("tie_wr_not_yet", int'(bus_if.wr_grant), 0);
        tick();
        check("tie_wr_grant_after", int'(bus_if.wr_grant), 1);
        for (int i = 0; i < 3; i++)
            wr_one(ADDR_W'($urandom_range(0, DEPTH - 1)), DATA_W'($urandom_range(0, 3)));
        release_wr();

        // Starvation: a writer waiting STARVE cycles revokes a reader that never lets go.
        bus_if.rd_req = 1'b1;
        bus_if.wr_req = 1'b1;
        tick();
        check("starve_rd_grant", int'(bus_if.rd_grant), 1);
        wait_m = 1;
        while (wait_m < STARVE) begin
            rd_one(ADDR_W'($urandom_range(0, DEPTH - 1)));
            wait_m++;
        end
        tick();
        check("starve_revoke_rd", int'(bus_if.rd_grant), 0);
        check("starve_revoke_wr", int'(bus_if.wr_grant), 0);
        tick();
        check("starve_wr_grant", int'(bus_if.wr_grant), 1);
        check("starve_rd_held_off", int'(bus_if.rd_grant), 0);
        tick();
        check("starve_wait_cleared", int'(dut.wr_wait_cnt_r), 0);
        wr_one(ADDR_W'($urandom_range(0, DEPTH - 1)), DATA_W'($urandom_range(0, 3)));
        wr_one(ADDR_W'($urandom_range(0, DEPTH - 1)), DATA_W'($urandom_range(0, 3)));
        release_wr();
        tick();
        check("starve_rd_regrant", int'(bus_if.rd_grant), 1);
        for (int i = 0; i < 3; i++) rd_one(ADDR_W'($urandom_range(0, DEPTH - 1)));
        release_rd();

        // Randomized independent bursts.
        repeat (20) begin
            n = $urandom_range(1, 6);
            if ($urandom_range(0, 1) == 1) begin
                acquire_wr();
                for (int i = 0; i < n; i++)
                    wr_one(ADDR_W'($urandom_range(0, DEPTH - 1)), DATA_W'($urandom_range(0, 3)));
                release_wr();
            end else begin
                acquire_rd();
                for (int i = 0; i < n; i++) rd_one(ADDR_W'($urandom_range(0, DEPTH - 1)));
                release_rd();
            end
        end

        // Fill with 0b11, then a clear requested mid-read pre-empts the reader.
        acquire_wr();
        for (int i = 0; i < DEPTH; i++) wr_one(ADDR_W'(i), 2'b11);
        release_wr();
        acquire_rd();
        for (int i = 0; i < 4; i++) rd_one(ADDR_W'($urandom_range(0, DEPTH - 1)));
        bus_if.clr_start = 1'b1;
        rd_one(ADDR_W'($urandom_range(0, DEPTH - 1)));
        bus_if.clr_start = 1'b0;
        tick();
        check("clr_rd_revoked", int'(bus_if.rd_grant), 0);
        tick();
        check("clr_busy_start", int'(bus_if.clr_busy), 1);
        busy_cycles = 1;
        tick();
        while (bus_if.clr_busy === 1'b1 && busy_cycles < 200) begin
            if (bus_if.rd_grant !== 1'b0 || bus_if.wr_grant !== 1'b0)
                check("clr_no_grant", int'(bus_if.rd_grant | bus_if.wr_grant), 0);
            busy_cycles++;
            tick();
        end
        check("clr_busy_cycles", busy_cycles, 64);
        check("clr_done_pulse", int'(bus_if.clr_done), 1);
        model_clear();
        tick();
        check("clr_done_one_cycle", int'(bus_if.clr_done), 0);
        check("clr_rd_regrant", int'(bus_if.rd_grant), 1);
        for (int i = 0; i < DEPTH; i++) rd_one(ADDR_W'(i));
        release_rd();

        // Reset during a write burst: 3 of 5 writes land, then everything returns to zero.
        base = ADDR_W'($urandom_range(0, DEPTH - 1));
        acquire_wr();
        for (int i = 0; i < 3; i++)
            wr_one(base + ADDR_W'(i), DATA_W'($urandom_range(1, 3)));
        rst_n_ = 1'b0;
        #1;
        check("rst_wr_grant", int'(bus_if.wr_grant), 0);
        check("rst_rd_grant", int'(bus_if.rd_grant), 0);
        check("rst_clr_busy", int'(bus_if.clr_busy), 0);
        model_clear();
        bus_if.wr_req = 1'b0;
        bus_if.wr_en  = 1'b0;
        tick();
        rst_n_ = 1'b1;
        tick();
        acquire_rd();
        for (int i = 0; i < 3; i++) rd_one(base + ADDR_W'(i));
        release_rd();

        repeat (3) tick();
        check("all_reads_returned", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/display_fb_responder.md
Name: display_fb_responder

Overview:
- Responder end of the frame-buffer read handshake (req/grant/valid/addr/data) used by the LED scan logic.
- Owns the 8x8 two-colour frame buffer: 64 cells, each {red, green}.
- Arbitrates between the scanner read port, a game-logic write port and an internal clear sequencer.
- Sits between the game state logic and the LED scanner in the display subsystem.

Parameters:
- ADDR_W, 6, cell address width; depth = 2**ADDR_W.
- DATA_W, 2, cell width; bit1 = red, bit0 = green.
- STARVE_LIMIT, 12, writer wait cycles before the reader is pre-empted.

Ports:
- scan_clk  in  1  clock.
- rst_n_  in  1  reset, asynchronous, active-low.
- rd_req  in  1  reader requests ownership; held while reading.
- rd_grant  out  1  reader owns the buffer.
- rd_addr  in  ADDR_W  read address {row[5:3], col[2:0]}.
- rd_valid  out  1  rd_data valid this cycle.
- rd_data  out  DATA_W  read data.
- wr_req  in  1  writer requests ownership.
- wr_grant  out  1  writer owns the buffer.
- wr_en  in  1  write strobe, honoured only while wr_grant=1.
- wr_addr  in  ADDR_W  write address.
- wr_data  in  DATA_W  write data.
- clr_start  in  1  single-cycle pulse requesting a full-buffer clear.
- clr_busy  out  1  clear sweep in progress.
- clr_done  out  1  one-cycle pulse when the sweep ends.

Behaviour:
- Reset state: FSM=IDLE; all memory cells 0; all outputs 0; clr_pending=0; wr_wait_cnt=0.
- Reset mid-operation aborts any grant or sweep immediately and returns to the reset state.
- clr_pending:
  - Set by clr_start in any state.
  - Cleared on entry to CLEAR.
  - A pulse during CLEAR re-arms it, so a second sweep follows.
- FSM states: IDLE, RD_OWN, WR_OWN, CLEAR.
- IDLE priority:
  - clr_pending -> CLEAR.
  - Else wr_req with wr_wait_cnt==STARVE_LIMIT -> WR_OWN.
  - Else rd_req -> RD_OWN.
  - Else wr_req -> WR_OWN.
  - The state register and the grant are registered together: grant goes high in the cycle after the winning req is sampled (1-cycle grant latency).
- RD_OWN:
  - rd_grant=1.
  - Each cycle with rd_req=1: rd_data <= mem[rd_addr] and rd_valid <= 1 (1-cycle latency). Otherwise rd_valid <= 0.
  - rd_req=0 -> IDLE; rd_grant low next cycle.
  - wr_wait_cnt==STARVE_LIMIT or clr_pending -> IDLE (revocation); rd_grant low next cycle. The reader must re-request and restart its line.
  - rd_valid never asserts in a cycle after rd_grant has dropped.
- WR_OWN:
  - wr_grant=1.
  - wr_en=1 writes mem[wr_addr] <= wr_data at the clock edge; the new value is visible to the first read issued after the grant changes.
  - wr_req=0 -> IDLE.
  - clr_pending -> IDLE, so the clear pre-empts the writer.
- Writer has no cap on hold time; it must release after its update burst.
- wr_wait_cnt:
  - Increments each cycle with wr_req=1 and wr_grant=0.
  - Saturates at STARVE_LIMIT.
  - Cleared in any cycle with wr_grant=1.
- CLEAR:
  - clr_busy=1.
  - 6-bit sweep counter starts at 0; each cycle mem[cnt] <= 0 and cnt increments.
  - After writing address 63 -> IDLE; clr_busy low and clr_done=1 for exactly one cycle.
  - Sweep takes exactly 64 cycles; no grants during CLEAR.
- Simultaneous rd_req and wr_req in IDLE without starvation: reader wins.
- Addresses wrap naturally at ADDR_W bits; there are no out-of-range addresses.

Test Plan:
- Reset, then wr_req=1 and write 0b10 to addr 9 and 0b01 to addr 63; release; rd_req=1, rd_addr=9 then 63 -> wr_grant at cycle+1; rd_data 2'b10 then 2'b01, each with rd_valid one cycle after the address.
- rd_req and wr_req asserted in the same cycle -> rd_grant first; reader holds 8 reads then releases -> wr_grant one cycle after rd_grant falls.
- Reader holds rd_req continuously while wr_req held -> rd_grant revoked after the writer has waited 12 cycles; wr_grant next cycle; wr_wait_cnt returns to 0.
- Fill buffer with 0b11, pulse clr_start mid-read -> rd_grant drops; clr_busy high for 64 cycles; clr_done pulse; all 64 reads return 0.
- Assert rst_n_ low during WR_OWN after 3 of 5 writes -> all grants and clr_busy low immediately; reads after reset return 0 at all 3 written addresses.
